// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: shared states, bus widths and geometry helpers for the instruction cache
package icache_sa_pkg;
    localparam int BEAT_W  = 64;
    localparam int INSTR_W = 32;
    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL, RESP, FLUSH} state_e;
    function automatic int log2c(input int v);
        return $clog2(v);
    endfunction
endpackage

// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch request/response, flush and refill signals between IFU, cache and memory
interface icache_sa_if #(parameter int ADDR_W = 64);
    import icache_sa_pkg::*;
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic               resp_valid;
    logic [INSTR_W-1:0] resp_data;
    logic               flush;
    logic               axi_r_req;
    logic [ADDR_W-1:0]  axi_req_addr;
    logic               ext_valid;
    logic [BEAT_W-1:0]  ext_data;
    logic               axi_last_data;
    modport slave (
        input  req_valid, req_addr, flush, ext_valid, ext_data, axi_last_data,
        output req_ready, resp_valid, resp_data, axi_r_req, axi_req_addr
    );
    modport master (
        output req_valid, req_addr, flush, ext_valid, ext_data, axi_last_data,
        input  req_ready, resp_valid, resp_data, axi_r_req, axi_req_addr
    );
endinterface

// File: rtl/icache_sa_plru.sv
// icache_sa_plru: per-set tree pseudo-LRU, WAYS-1 bits per set, heap-ordered (root = bit 0)
module icache_sa_plru #(
    parameter int WAYS = 4,
    parameter int SETS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic [$clog2(SETS)-1:0] idx_i,
    input  logic                    upd_i,
    input  logic [$clog2(WAYS)-1:0] upd_way_i,
    output logic [$clog2(WAYS)-1:0] victim_o
);
    localparam int LW = $clog2(WAYS);
    logic [WAYS-2:0] tree_q [SETS];
    logic [WAYS-2:0] row, row_d, mask;
    logic [LW:0]     node, unode;
    logic [LW-1:0]   way;
    logic            d;
    // Walk from the root following each bit; a set bit means the right half is colder
    always_comb begin
        row = tree_q[idx_i];
        node = (LW+1)'(1);
        for (int l = 0; l < LW; l++) node = {node[LW-1:0], 1'(row >> (node - 1'b1))};
        victim_o = node[LW-1:0];
    end
    // Point every node on the path of the touched way at the opposite subtree
    always_comb begin
        row_d = row;
        unode = (LW+1)'(1);
        way = upd_way_i;
        d = 1'b0;
        mask = '0;
        for (int l = 0; l < LW; l++) begin
            d = way[LW-1];
            mask = (WAYS-1)'(1) << (unode - 1'b1);
            row_d = d ? (row_d & ~mask) : (row_d | mask);
            unode = {unode[LW-1:0], d};
            way = way << 1;
        end
    end
    // Tree bits are flops so reset and flush can zero every set in one cycle
    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else if (upd_i) begin
            tree_q[idx_i] <= row_d;
        end
    end
endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache, 2-cycle hits, whole-line beat refill, fence.i flush
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 64
) (
    input logic        clk,
    input logic        rst,
    icache_sa_if.slave bus
);
    localparam int BEATS = LINE_BYTES / 8;
    localparam int OFF_W = log2c(LINE_BYTES);
    localparam int IDX_W = log2c(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = log2c(WAYS);
    localparam int CNT_W = log2c(BEATS);

    state_e             state_q, state_d;
    logic [ADDR_W-1:2]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAY_W-1:0]   victim_q, victim_d, hit_way, inv_way, plru_victim, plru_way;
    logic               flush_pend_q, flush_pend_d, resp_valid_q, resp_valid_d;
    logic [INSTR_W-1:0] resp_data_q, resp_data_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]   tag_q [WAYS][SETS];
    logic [BEAT_W-1:0]  data_q [WAYS][SETS*BEATS];
    logic               hit, inv_any, plru_upd, fill_we, tag_we;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [CNT_W-1:0]   beat;
    logic [BEAT_W-1:0]  hit_beat;

    assign idx      = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign beat     = addr_q[OFF_W-1:3];
    assign hit_beat = data_q[hit_way][{idx, beat}];

    assign bus.req_ready    = state_q == IDLE && !bus.flush;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.axi_r_req    = state_q == REFILL_REQ;
    assign bus.axi_req_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    icache_sa_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == FLUSH),
        .idx_i     (idx),
        .upd_i     (plru_upd),
        .upd_way_i (plru_way),
        .victim_o  (plru_victim)
    );

    // Tag match across the indexed set, plus the lowest-numbered empty way for refill
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    // Controller: a flush seen while busy is deferred until the current fetch has responded
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        victim_d = victim_q;
        flush_pend_d = flush_pend_q | (bus.flush && state_q != IDLE);
        resp_valid_d = 1'b0;
        resp_data_d = resp_data_q;
        plru_upd = 1'b0;
        plru_way = hit_way;
        fill_we = 1'b0;
        tag_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) state_d = FLUSH;
                else if (bus.req_valid) begin
                    addr_d = bus.req_addr[ADDR_W-1:2];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d = addr_q[2] ? hit_beat[63:32] : hit_beat[31:0];
                    plru_upd = 1'b1;
                    state_d = flush_pend_d ? FLUSH : IDLE;
                end else state_d = REFILL_REQ;
            end
            REFILL_REQ: begin
                victim_d = inv_any ? inv_way : plru_victim;
                cnt_d = '0;
                state_d = REFILL;
            end
            REFILL: begin
                if (bus.ext_valid) begin
                    fill_we = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == beat) resp_data_d = addr_q[2] ? bus.ext_data[63:32] : bus.ext_data[31:0];
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        tag_we = 1'b1;
                        plru_upd = 1'b1;
                        plru_way = victim_q;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                resp_valid_d = 1'b1;
                state_d = flush_pend_d ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_pend_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            cnt_q <= '0;
            victim_q <= '0;
            flush_pend_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            victim_q <= victim_d;
            flush_pend_q <= flush_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Valid bits: the line becomes visible only once its final beat has landed
    always_ff @(posedge clk) begin
        if (!rst || state_q == FLUSH) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (tag_we) begin
            valid_q[idx][victim_q] <= 1'b1;
        end
    end

    // Tag and data storage, not reset
    always_ff @(posedge clk) begin
        if (fill_we) data_q[victim_q][{idx, cnt_q}] <= bus.ext_data;
        if (tag_we) tag_q[victim_q][idx] <= tag;
    end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed checks of hits, refills, victim choice, flush and reset for icache_sa
module tb_icache_sa;
    localparam int BEATS = 8;
    logic clk;
    logic rst;
    int checks = 0;
    int errors = 0;
    int busy_rdy;
    int flush_beat;
    logic hold;
    int lat;
    int nreq;
    int extra;
    logic [31:0] data;
    logic [63:0] raddr;

    icache_sa_if #(.ADDR_W(64)) bus ();

    icache_sa #(.WAYS(4), .SETS(64), .LINE_BYTES(64), .ADDR_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordof(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] beat_of(input logic [63:0] base, input int b);
        logic [63:0] a;
        a = base + 64'(b * 8);
        return {wordof(a + 64'd4), wordof(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] a);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        chk("accept", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = hold;
    endtask

    task automatic wait_resp(output int l, output logic [31:0] d, output int nr, output logic [63:0] ra);
        l = 0;
        d = '0;
        nr = 0;
        ra = '0;
        busy_rdy = 0;
        for (int n = 1; n <= 80 && l == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.resp_valid) begin
                l = n;
                d = bus.resp_data;
            end else begin
                if (bus.req_ready) busy_rdy++;
                if (bus.axi_r_req) begin
                    nr++;
                    ra = bus.axi_req_addr;
                    for (int b = 0; b < BEATS; b++) begin
                        @(negedge clk);
                        if (bus.req_ready) busy_rdy++;
                        bus.ext_valid = 1'b1;
                        bus.ext_data = beat_of(ra, b);
                        bus.axi_last_data = (b == BEATS - 1);
                        bus.flush = (b == flush_beat);
                    end
                    @(negedge clk);
                    bus.ext_valid = 1'b0;
                    bus.axi_last_data = 1'b0;
                    bus.flush = 1'b0;
                end
            end
        end
        chk("resp_seen", 64'(l != 0), 64'd1);
    endtask

    task automatic run(input logic [63:0] a, input int exp_nreq, input string tag);
        send(a);
        wait_resp(lat, data, nreq, raddr);
        chk({tag, "_nreq"}, 64'(nreq), 64'(exp_nreq));
        chk({tag, "_data"}, 64'(data), 64'(wordof(a)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        hold = 1'b0;
        flush_beat = -1;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.flush = 1'b0;
        bus.ext_valid = 1'b0;
        bus.ext_data = '0;
        bus.axi_last_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_axi_req", 64'(bus.axi_r_req), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_axi_addr", bus.axi_req_addr, 64'd0);
        rst = 1'b1;

        send(64'h8000_0004);
        wait_resp(lat, data, nreq, raddr);
        chk("cold_nreq", 64'(nreq), 64'd1);
        chk("cold_addr", raddr, 64'h8000_0000);
        chk("cold_data", 64'(data), 64'h9357_9BDB);

        send(64'h8000_0038);
        wait_resp(lat, data, nreq, raddr);
        chk("hit_lat", 64'(lat), 64'd2);
        chk("hit_nreq", 64'(nreq), 64'd0);
        chk("hit_data", 64'(data), 64'h9357_9BE7);

        hold = 1'b1;
        send(64'h8000_1008);
        wait_resp(lat, data, nreq, raddr);
        chk("hold_nreq", 64'(nreq), 64'd1);
        chk("hold_data", 64'(data), 64'(wordof(64'h8000_1008)));
        chk("hold_busy_ready", 64'(busy_rdy), 64'd0);
        chk("hold_ready", 64'(bus.req_ready & bus.req_valid), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        hold = 1'b0;
        wait_resp(lat, data, nreq, raddr);
        chk("hold2_lat", 64'(lat), 64'd2);
        chk("hold2_nreq", 64'(nreq), 64'd0);
        chk("hold2_data", 64'(data), 64'(wordof(64'h8000_1008)));
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            extra += int'(bus.resp_valid | bus.axi_r_req);
        end
        chk("hold_extra", 64'(extra), 64'd0);

        run(64'h0001_0040, 1, "lru_a");
        run(64'h0002_0040, 1, "lru_b");
        run(64'h0001_0040, 0, "lru_a_touch");
        run(64'h0003_0040, 1, "lru_c");
        run(64'h0004_0044, 1, "lru_d");
        run(64'h0005_0048, 1, "lru_e");
        run(64'h0001_0040, 0, "lru_a_kept");
        run(64'h0002_0040, 1, "lru_b_evicted");

        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        run(64'h8000_0038, 1, "flush_idle");

        flush_beat = 4;
        run(64'h8000_3020, 1, "flush_mid");
        flush_beat = -1;
        run(64'h8000_3020, 1, "after_flush");

        send(64'h8000_2010);
        for (int i = 0; i < 10 && !bus.axi_r_req; i++) @(negedge clk);
        chk("rstmid_areq", 64'(bus.axi_r_req), 64'd1);
        raddr = bus.axi_req_addr;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            bus.ext_valid = 1'b1;
            bus.ext_data = beat_of(raddr, b);
            bus.axi_last_data = (b == BEATS - 1);
            rst = (b != 3);
        end
        @(negedge clk);
        bus.ext_valid = 1'b0;
        bus.axi_last_data = 1'b0;
        chk("rstmid_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rstmid_ready", 64'(bus.req_ready), 64'd1);
        chk("rstmid_resp_data", 64'(bus.resp_data), 64'd0);
        send(64'h8000_2010);
        wait_resp(lat, data, nreq, raddr);
        chk("rstmid_nreq", 64'(nreq), 64'd1);
        chk("rstmid_addr", raddr, 64'h8000_2000);
        chk("rstmid_data", 64'(data), 64'(wordof(64'h8000_2010)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
